// File: rtl/vmsu_pkg.sv
// Shared state encoding and arithmetic helpers for the vmsu sequential multiplier.
package vmsu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINAL} vmsu_state_e;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic logic [63:0] twos_neg(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

  // Magnitude of a width-bit value held zero-extended in x; the most negative
  // value maps to 2^(width-1), which still fits in width unsigned bits.
  function automatic logic [63:0] abs_val(input logic [63:0] x, input int width, input logic en);
    if (en && (((x >> (width - 1)) & 64'd1) != 64'd0))
      return twos_neg(x) & ((64'd1 << width) - 64'd1);
    return x;
  endfunction

endpackage

// File: rtl/vmsu_pp_step.sv
// One RUN step: adds |a| times the low BPC bits of the shifting accumulator
// into its upper half, then shifts the whole accumulator right by BPC.
module vmsu_pp_step #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH+BPC-1:0] partial;
  logic [WIDTH+BPC-1:0] sum;

  always_comb begin
    partial = (WIDTH+BPC)'(mcand) * (WIDTH+BPC)'(acc_in[BPC-1:0]);
    sum     = (WIDTH+BPC)'(acc_in[2*WIDTH-1:WIDTH]) + partial;
  end

  // The lower half still holds the unretired multiplier bits.
  generate
    if (BPC == WIDTH) begin : g_single
      assign acc_out = sum;
    end else begin : g_shift
      assign acc_out = {sum, acc_in[WIDTH-1:BPC]};
    end
  endgenerate

endmodule

// File: rtl/vmsu_mult_seq.sv
// Iterative sign-magnitude multiplier with start/done handshake and an
// optional accumulate mode carrying a sticky overflow flag.
module vmsu_mult_seq #(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic               signed_mode,
  input  logic               acc_en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               acc_ovf
);
  import vmsu_pkg::*;

  localparam int ITERS = iter_count(WIDTH, BPC);
  localparam int CNT_W = $clog2(ITERS + 1);

  vmsu_state_e        state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod, prod_step;
  logic [WIDTH-1:0]   mcand;
  logic               neg, acc_mode, sgn_mode;
  logic               last_step, accept;
  logic [2*WIDTH-1:0] signed_prod, p_nxt;
  logic [2*WIDTH:0]   acc_sum;
  logic               ovf_nxt;

  vmsu_pp_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .acc_in (prod),
    .mcand  (mcand),
    .acc_out(prod_step)
  );

  // The done cycle doubles as an idle cycle so results can stream back-to-back.
  assign accept    = start && !clear && (state == IDLE || state == FINAL);
  assign last_step = (state == RUN) && (cnt == CNT_W'(ITERS - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == FINAL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = FINAL;
      FINAL:   state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_comb begin
    signed_prod = neg ? (2*WIDTH)'(twos_neg(64'(prod_step))) : prod_step;
    acc_sum     = {1'b0, p} + {1'b0, signed_prod};
    p_nxt       = acc_mode ? acc_sum[2*WIDTH-1:0] : signed_prod;
    ovf_nxt     = acc_ovf;
    if (acc_mode) begin
      if (sgn_mode)
        ovf_nxt = acc_ovf | ((p[2*WIDTH-1] == signed_prod[2*WIDTH-1]) &&
                             (acc_sum[2*WIDTH-1] != p[2*WIDTH-1]));
      else
        ovf_nxt = acc_ovf | acc_sum[2*WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      prod     <= '0;
      mcand    <= '0;
      neg      <= 1'b0;
      acc_mode <= 1'b0;
      sgn_mode <= 1'b0;
      p        <= '0;
      acc_ovf  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        cnt     <= '0;
        p       <= '0;
        acc_ovf <= 1'b0;
      end else if (accept) begin
        cnt      <= '0;
        mcand    <= WIDTH'(abs_val(64'(a), WIDTH, signed_mode));
        prod     <= {{WIDTH{1'b0}}, WIDTH'(abs_val(64'(b), WIDTH, signed_mode))};
        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_mode <= acc_en;
        sgn_mode <= signed_mode;
      end else if (state == RUN) begin
        prod <= prod_step;
        cnt  <= cnt + CNT_W'(1);
        if (last_step) begin
          p       <= p_nxt;
          acc_ovf <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_vmsu_mult_seq.sv
// Scoreboard bench for vmsu_mult_seq: an 8-bit/1-bit-per-cycle instance and a
// 16-bit/4-bit-per-cycle instance checked against an arithmetic reference model.
module tb_vmsu_mult_seq;

  typedef struct {
    longint p;
    bit     ovf;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  logic        start8 = 0, clear8 = 0, sm8 = 0, acc8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, ovf8;
  logic [15:0] p8;

  logic        start16 = 0, clear16 = 0, sm16 = 0, acc16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, done16, ovf16;
  logic [31:0] p16;

  exp_t   sb0[$];
  exp_t   sb1[$];
  longint mp[2];
  bit     mo[2];
  longint last_p[2];
  int     tests = 0;
  int     fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vmsu_mult_seq #(.WIDTH(8), .BPC(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .clear(clear8), .signed_mode(sm8),
    .acc_en(acc8), .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8), .acc_ovf(ovf8)
  );

  vmsu_mult_seq #(.WIDTH(16), .BPC(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .clear(clear16), .signed_mode(sm16),
    .acc_en(acc16), .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16), .acc_ovf(ovf16)
  );

  // Per-instance accessors so the tasks below can be shared by both DUTs.
  function automatic int width_of(int sel);
    return (sel != 0) ? 16 : 8;
  endfunction

  function automatic int iters_of(int sel);
    return (sel != 0) ? 4 : 8;
  endfunction

  function automatic bit get_busy(int sel);
    return (sel != 0) ? busy16 : busy8;
  endfunction

  function automatic bit get_done(int sel);
    return (sel != 0) ? done16 : done8;
  endfunction

  function automatic bit get_ovf(int sel);
    return (sel != 0) ? ovf16 : ovf8;
  endfunction

  function automatic longint get_p(int sel);
    return (sel != 0) ? longint'(p16) : longint'(p8);
  endfunction

  function automatic int sbSize(int sel);
    return (sel != 0) ? sb1.size() : sb0.size();
  endfunction

  function automatic void sbPush(int sel, exp_t e);
    if (sel != 0) sb1.push_back(e);
    else sb0.push_back(e);
  endfunction

  function automatic exp_t sbPop(int sel);
    if (sel != 0) return sb1.pop_front();
    return sb0.pop_front();
  endfunction

  function automatic void sbFlush(int sel);
    if (sel != 0) sb1.delete();
    else sb0.delete();
  endfunction

  // Reference model: plain integer arithmetic on the operands' numeric values.
  function automatic longint toValue(longint v, int w, bit sm);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (sm && m[w-1]) return m - (longint'(1) << w);
    return m;
  endfunction

  function automatic void modelOp(int sel, longint a, longint b, bit sm, bit acc);
    int     w;
    longint mask, prod, s;
    w    = width_of(sel);
    mask = (longint'(1) << (2 * w)) - 1;
    prod = toValue(a, w, sm) * toValue(b, w, sm);
    if (!acc) begin
      mp[sel] = prod & mask;
    end else if (sm) begin
      s = toValue(mp[sel], 2 * w, 1'b1) + prod;
      if (s > (longint'(1) << (2 * w - 1)) - 1 || s < -(longint'(1) << (2 * w - 1)))
        mo[sel] = 1'b1;
      mp[sel] = s & mask;
    end else begin
      s = mp[sel] + (prod & mask);
      if (s > mask) mo[sel] = 1'b1;
      mp[sel] = s & mask;
    end
  endfunction

  function automatic longint pickOperand(int w);
    case ($urandom_range(0, 3))
      0:       return longint'(1) << (w - 1);
      1:       return (longint'(1) << w) - 1;
      default: return longint'($urandom) & ((longint'(1) << w) - 1);
    endcase
  endfunction

  task automatic checkOutput(string name, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic setInputs(int sel, longint a, longint b, bit sm, bit acc, bit st);
    if (sel != 0) begin
      a16 = 16'(a); b16 = 16'(b); sm16 = sm; acc16 = acc; start16 = st;
    end else begin
      a8 = 8'(a); b8 = 8'(b); sm8 = sm; acc8 = acc; start8 = st;
    end
  endtask

  task automatic setClear(int sel, bit v);
    if (sel != 0) clear16 = v;
    else clear8 = v;
  endtask

  // Issue one operation as soon as the DUT can take it (idle or done cycle);
  // the expected result and its due cycle go onto the scoreboard.
  task automatic applyStimulus(int sel, longint a, longint b, bit sm, bit acc);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (get_busy(sel) && !get_done(sel)) begin
      guard++;
      if (guard > 100) begin
        checkOutput("issue_timeout", longint'(guard), 0);
        return;
      end
      @(negedge clk);
    end
    setInputs(sel, a, b, sm, acc, 1'b1);
    modelOp(sel, a, b, sm, acc);
    e.p   = mp[sel];
    e.ovf = mo[sel];
    e.due = cyc + iters_of(sel) + 1;
    sbPush(sel, e);
    @(posedge clk);
    #1;
    setInputs(sel, longint'($urandom), longint'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
    checkOutput("busy_after_start", longint'(get_busy(sel)), 1);
  endtask

  // Synchronous clear, avoiding the done cycle so nothing is mid-pop.
  task automatic clearOp(int sel);
    @(negedge clk);
    if (get_done(sel)) @(negedge clk);
    setClear(sel, 1'b1);
    sbFlush(sel);
    mp[sel] = 0;
    mo[sel] = 1'b0;
    @(posedge clk);
    #1;
    setClear(sel, 1'b0);
    last_p[sel] = 0;
    checkOutput("clear_busy", longint'(get_busy(sel)), 0);
    checkOutput("clear_done", longint'(get_done(sel)), 0);
    checkOutput("clear_p", get_p(sel), 0);
    checkOutput("clear_ovf", longint'(get_ovf(sel)), 0);
  endtask

  task automatic waitDrain(int sel);
    int guard;
    guard = 0;
    @(negedge clk);
    while (sbSize(sel) != 0 || get_busy(sel)) begin
      guard++;
      if (guard > 200) begin
        checkOutput("drain_timeout", longint'(sbSize(sel)), 0);
        sbFlush(sel);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry, arrive in
  // its due cycle, and p must hold steady in every other cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (get_done(s)) begin
        if (sbSize(s) == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = sbPop(s);
          checkOutput((s != 0) ? "p16" : "p8", get_p(s), e.p);
          checkOutput((s != 0) ? "ovf16" : "ovf8", longint'(get_ovf(s)), longint'(e.ovf));
          checkOutput("done_cycle", longint'(cyc), longint'(e.due));
          last_p[s] = e.p;
        end
      end else begin
        checkOutput("p_hold", get_p(s), last_p[s]);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sel;
    mp[0] = 0; mp[1] = 0; mo[0] = 0; mo[1] = 0; last_p[0] = 0; last_p[1] = 0;

    // Asynchronous reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_busy", longint'(get_busy(s)), 0);
      checkOutput("reset_done", longint'(get_done(s)), 0);
      checkOutput("reset_p", get_p(s), 0);
      checkOutput("reset_ovf", longint'(get_ovf(s)), 0);
    end
    #18 rst = 1'b0;

    // Directed 8-bit products, unsigned and signed corner operands.
    applyStimulus(0, 'hFF, 'hFF, 1'b0, 1'b0);
    applyStimulus(0, 'h80, 'h80, 1'b1, 1'b0);
    applyStimulus(0, 'hFD, 'h05, 1'b1, 1'b0);
    applyStimulus(0, 'h7F, 'h81, 1'b1, 1'b0);
    waitDrain(0);

    // Signed accumulate overflowing on the third step; flag must stick.
    clearOp(0);
    applyStimulus(0, 'h7F, 'h7F, 1'b1, 1'b1);
    applyStimulus(0, 'h7F, 'h7F, 1'b1, 1'b1);
    applyStimulus(0, 'h7F, 'h7F, 1'b1, 1'b1);
    applyStimulus(0, 'h03, 'h04, 1'b0, 1'b0);
    waitDrain(0);
    checkOutput("ovf_sticky", longint'(ovf8), 1);
    clearOp(0);

    // Wide instance retiring four bits per cycle.
    applyStimulus(1, 'hFFFF, 'h0002, 1'b0, 1'b0);
    waitDrain(1);

    // A second start during RUN must be ignored entirely.
    applyStimulus(0, 'hA5, 'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    setInputs(0, 'h11, 'h22, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1 setInputs(0, 'h00, 'h00, 1'b0, 1'b0, 1'b0);
    waitDrain(0);

    // Clear during RUN aborts the operation without a done pulse.
    applyStimulus(0, 'h9C, 'h47, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    clearOp(0);
    waitDrain(0);

    // Randomized mix across both instances with occasional clears.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0)
        clearOp(sel);
      else
        applyStimulus(sel, pickOperand(width_of(sel)), pickOperand(width_of(sel)),
                      $urandom_range(0, 1), $urandom_range(0, 1));
    end
    waitDrain(0);
    waitDrain(1);

    // Asynchronous reset in the middle of an 8-bit RUN.
    applyStimulus(0, 'hFF, 'h7E, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    sbFlush(0); sbFlush(1);
    mp[0] = 0; mp[1] = 0; mo[0] = 0; mo[1] = 0; last_p[0] = 0; last_p[1] = 0;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", longint'(busy8), 0);
    checkOutput("async_rst_done", longint'(done8), 0);
    checkOutput("async_rst_p", longint'(p8), 0);
    checkOutput("async_rst_ovf", longint'(ovf8), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
